// File: rtl/expr_mac_sequencer.sv
// Feeds operand pairs to an iterative multiplier via start/done and accumulates the 16-bit sum of products.
// done asserts sum(1+L_k)+1 cycles after start (1 cycle when count is 0); waits indefinitely on mul_done.
module expr_mac_sequencer #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] count,
  output logic [WIDTH-1:0]  mul_x,
  output logic [WIDTH-1:0]  mul_y,
  output logic              mul_start,
  input  logic              mul_done,
  input  logic [WIDTH-1:0]  mul_out,
  output logic [WIDTH-1:0]  result,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int PAIRS = DEPTH / 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] n_q;
  logic [WIDTH-1:0]  acc;

  logic [ADDR_W-1:0] n_eff;
  logic [ADDR_W-1:0] nxt_idx;
  logic [ADDR_W-1:0] x_addr;
  logic [ADDR_W-1:0] y_addr;
  logic [WIDTH-1:0]  op_x;
  logic [WIDTH-1:0]  op_y;
  logic [WIDTH:0]    sum;
  logic              wr_ok;
  logic              last;

  assign n_eff   = (count > ADDR_W'(PAIRS)) ? ADDR_W'(PAIRS) : count;
  assign nxt_idx = (state == S_WAIT) ? idx + ADDR_W'(1) : '0;
  assign x_addr  = {nxt_idx[ADDR_W-2:0], 1'b0};
  assign y_addr  = {nxt_idx[ADDR_W-2:0], 1'b1};
  assign wr_ok   = wr_en && !busy;
  assign sum     = {1'b0, acc} + {1'b0, mul_out};
  assign last    = (idx == n_q - ADDR_W'(1));

  // Operands are captured on entry to ISSUE; forward a same-edge write so ISSUE sees the new value.
  always_comb begin
    op_x = mem[x_addr];
    op_y = mem[y_addr];
    if (wr_ok && wr_addr == x_addr) op_x = wr_data;
    if (wr_ok && wr_addr == y_addr) op_y = wr_data;
  end

  assign mul_start = (state == S_ISSUE);
  assign busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      n_q      <= '0;
      acc      <= '0;
      result   <= '0;
      overflow <= 1'b0;
      mul_x    <= '0;
      mul_y    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      case (state)
        S_IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            if (n_eff != '0) begin
              acc   <= '0;
              idx   <= '0;
              n_q   <= n_eff;
              mul_x <= op_x;
              mul_y <= op_y;
              state <= S_ISSUE;
            end else begin
              result <= '0;
              state  <= S_DONE;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mul_done) begin
            acc      <= sum[WIDTH-1:0];
            overflow <= overflow | sum[WIDTH];
            if (last) begin
              result <= sum[WIDTH-1:0];
              state  <= S_DONE;
            end else begin
              idx   <= nxt_idx;
              mul_x <= op_x;
              mul_y <= op_y;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
